// File: rtl/mult_operand_stager.sv
// Front end for the shift-add multiplier: it synchronises the load pin, queues operand pairs and issues one multiply at a time.
// Pin-to-start is 4 edges. A full FIFO drops loads (sticky drop), and an unacknowledged result stalls issue.
module mult_operand_stager #(
    parameter int W       = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             ld_pin,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_p,
    output logic [2*W-1:0]   res,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             full,
    output logic             drop,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [TW-1:0] C_WD_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;

    logic [2*W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [TW-1:0]    r_wd;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic             r_mul_start;
    logic [2*W-1:0]   r_res;
    logic             r_res_valid;
    logic             r_drop;
    logic             r_err;

    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_drop_evt;
    logic             w_capture;
    logic             w_timeout;
    logic [2*W-1:0]   w_head;

    // Two-flop synchroniser plus a history flop, so a held pin produces a single push.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= ld_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_push     = r_s2 & ~r_s3;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    // While the FIFO is full, a push still succeeds if the same edge pops the head slot it overwrites.
    assign w_wr       = w_push & (~w_full | w_pop);
    assign w_drop_evt = w_push & w_full & ~w_pop;
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && w_wr) begin
            r_mem[r_wptr] <= {a_in, b_in};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && (!r_res_valid || res_ack)) begin
                    w_pop  = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_IDLE;
                end else if (r_wd == C_WD_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wd <= '0;
        end else if (r_state == ST_START) begin
            r_wd <= '0;
        end else if (r_state == ST_WAIT && !w_capture && !w_timeout) begin
            r_wd <= r_wd + TW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
        end else begin
            r_mul_start <= w_pop;
            if (w_pop) begin
                r_mul_a <= w_head[2*W-1:W];
                r_mul_b <= w_head[W-1:0];
            end
        end
    end

    // A capture takes priority over an ack in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res       <= mul_p;
            r_res_valid <= 1'b1;
        end else if (res_ack && r_res_valid) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_drop <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_drop <= r_drop | w_drop_evt;
            r_err  <= r_err | w_timeout;
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_mul_start;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign full      = w_full;
    assign drop      = r_drop;
    assign err       = r_err;

endmodule
